// File: rtl/div_pkg.sv
// Shared definitions for the shift-subtract divider datapath and its controller.
// Controller state encodings live here so benches can label divider phases.
package div_pkg;

    localparam int DIV_WIDTH = 4;

    typedef enum logic [3:0] {
        S0 = 4'd0,
        S1 = 4'd1,
        S2 = 4'd2,
        S3 = 4'd3,
        S4 = 4'd4
    } ctrl_state_t;

endpackage

// File: rtl/divide_datapath_trial_subtractor.sv
// Combinational trial subtraction for the restoring divider.
// Borrow out of the extended subtract flags a negative difference.
module trial_subtractor #(
    parameter int WIDTH = div_pkg::DIV_WIDTH
) (
    input  logic [WIDTH:0]   minuend,
    input  logic [WIDTH:0]   subtrahend,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] full;

    assign full   = minuend - subtrahend;
    assign diff   = full[WIDTH-1:0];
    assign borrow = full[WIDTH];

endmodule

// File: rtl/divide_datapath.sv
// Operand/remainder datapath for the restoring divider, driven by controller strobes.
// Optional DIVZERO_GUARD_EN adds a sticky div_zero flag and forces comp high on /0.
module divide_datapath
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             START,
    input  logic             SHIFT,
    input  logic             LOAD,
    input  logic             DONE,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             comp,
    output logic             busy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             result_valid,
    output logic             proto_err
`ifdef DIVZERO_GUARD_EN
    ,
    output logic             div_zero
`endif
);

    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic             done_q;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    // During SHIFT the trial looks ahead at the value about to be shifted in
    assign trial = SHIFT ? {rem, quo[WIDTH-1]} : {1'b0, rem};

    trial_subtractor #(
        .WIDTH(WIDTH)
    ) u_sub (
        .minuend   (trial),
        .subtrahend({1'b0, dvs}),
        .diff      (diff),
        .borrow    (borrow)
    );

`ifdef DIVZERO_GUARD_EN
    assign comp = borrow | div_zero;
`else
    assign comp = borrow;
`endif

    assign quotient  = quo;
    assign remainder = rem;

    always_ff @(posedge clock) begin
        if (reset) begin
            quo          <= '0;
            rem          <= '0;
            dvs          <= '0;
            busy         <= 1'b0;
            done_q       <= 1'b0;
            result_valid <= 1'b0;
            proto_err    <= 1'b0;
`ifdef DIVZERO_GUARD_EN
            div_zero     <= 1'b0;
`endif
        end else begin
            done_q       <= DONE;
            result_valid <= DONE & ~done_q;
            if (START && !busy) begin
                quo  <= dividend;
                rem  <= '0;
                dvs  <= divisor;
                busy <= 1'b1;
`ifdef DIVZERO_GUARD_EN
                div_zero <= (divisor == '0);
`endif
            end else if (busy) begin
                if (DONE && !done_q) begin
                    busy <= 1'b0;
                end
                if (SHIFT && LOAD) begin
                    proto_err <= 1'b1;
                end else if (SHIFT) begin
                    {rem, quo} <= {rem, quo} << 1;
                end else if (LOAD) begin
                    rem    <= diff;
                    quo[0] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_divide_datapath.sv
// Scoreboard bench for divide_datapath; emulates the controller strobe sequence.
// Define DIVZERO_GUARD_EN to exercise the divide-by-zero guard build.
module tb_divide_datapath;
    import div_pkg::*;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         START, SHIFT, LOAD, DONE;
    logic [W-1:0] dividend, divisor;
    logic         comp, busy, result_valid, proto_err;
    logic [W-1:0] quotient, remainder;
`ifdef DIVZERO_GUARD_EN
    logic         div_zero;
`endif

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb[$];
    ctrl_state_t st = S0;

    always #5 clock = ~clock;

    divide_datapath #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .START       (START),
        .SHIFT       (SHIFT),
        .LOAD        (LOAD),
        .DONE        (DONE),
        .dividend    (dividend),
        .divisor     (divisor),
        .comp        (comp),
        .busy        (busy),
        .quotient    (quotient),
        .remainder   (remainder),
        .result_valid(result_valid),
        .proto_err   (proto_err)
`ifdef DIVZERO_GUARD_EN
        ,
        .div_zero    (div_zero)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s state=%s actual=%0h expected=%0h",
                     name, st.name(), act, exp);
        end
    endtask

    // Monitor: every result_valid pulse pops one expected result
    always @(negedge clock) begin
        if (result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%0h/%0h expected=none",
                         quotient, remainder);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
            end
        end
    end

    // Controller emulation; cseq[3] is the first iteration's expected comp
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] cseq, input logic [W-1:0] qe,
                          input logic [W-1:0] re, input bit inject);
        logic c;
        sb.push_back('{q: qe, r: re});
        st = S1;
        START = 1'b1; dividend = a; divisor = b;
        @(negedge clock);
        START = 1'b0;
        chk("busy_after_capture", 32'(busy), 32'd1);
        for (int i = 0; i < W; i++) begin
            st = S2;
            SHIFT = 1'b1;
            if (inject && i == 0) begin
                START = 1'b1; dividend = 4'd5; divisor = 4'd5;
            end
            #1;
            c = comp;
            chk($sformatf("comp_it%0d", i), 32'(c), 32'(cseq[3-i]));
            @(negedge clock);
            START = 1'b0;
            SHIFT = 1'b0;
            st = S3;
            #1;
            chk($sformatf("comp_stable_it%0d", i), 32'(comp), 32'(c));
            if (!c) begin
                LOAD = 1'b1;
                @(negedge clock);
                LOAD = 1'b0;
            end
        end
        st = S4;
        DONE = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("result_valid_one_cycle", 32'(result_valid), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        DONE = 1'b0;
        st = S0;
        @(negedge clock);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_quotient"}, 32'(quotient), 32'd0);
        chk({tag, "_remainder"}, 32'(remainder), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "_proto_err"}, 32'(proto_err), 32'd0);
        chk({tag, "_comp"}, 32'(comp), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        START = 1'b0; SHIFT = 1'b0; LOAD = 1'b0; DONE = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check_all_zero("reset");

        run_op(4'd13, 4'd3, 4'b1011, 4'd4, 4'd1, 1'b0);
        run_op(4'd15, 4'd1, 4'b0000, 4'd15, 4'd0, 1'b0);
        run_op(4'd7, 4'd9, 4'b1111, 4'd0, 4'd7, 1'b0);
`ifdef DIVZERO_GUARD_EN
        run_op(4'd6, 4'd0, 4'b1111, 4'd0, 4'd6, 1'b0);
        chk("div_zero_set", 32'(div_zero), 32'd1);
`else
        run_op(4'd6, 4'd0, 4'b0000, 4'd15, 4'd6, 1'b0);
`endif

        // Abort 13/3 with reset after its second SHIFT
        START = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clock);
        START = 1'b0;
        SHIFT = 1'b1;
        @(negedge clock);
        @(negedge clock);
        SHIFT = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_all_zero("midop_reset");
        run_op(4'd9, 4'd2, 4'b1011, 4'd4, 4'd1, 1'b0);

        run_op(4'd13, 4'd3, 4'b1011, 4'd4, 4'd1, 1'b1);

        // Illegal SHIFT+LOAD must freeze operands and latch proto_err
        START = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clock);
        START = 1'b0;
        SHIFT = 1'b1; LOAD = 1'b1;
        @(negedge clock);
        SHIFT = 1'b0; LOAD = 1'b0;
        chk("proto_err_set", 32'(proto_err), 32'd1);
        chk("proto_quotient_held", 32'(quotient), 32'd13);
        chk("proto_remainder_held", 32'(remainder), 32'd0);
        @(negedge clock);
        chk("proto_err_sticky", 32'(proto_err), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("proto_err_cleared", 32'(proto_err), 32'd0);

        repeat (2) @(negedge clock);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
